// File: rtl/int_reg_write_arbiter.sv
// Integer register-file write port arbiter: commit writes win,
// late results queue in a small FIFO and drain when the port is free.
module int_reg_write_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int QUEUE_DEPTH  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid,
  input  logic [ADDR_WIDTH-1:0] commit_addr,
  input  logic [DATA_WIDTH-1:0] commit_value,
  input  logic                  late_valid,
  output logic                  late_ready,
  input  logic [ADDR_WIDTH-1:0] late_addr,
  input  logic [DATA_WIDTH-1:0] late_value,
  input  logic [ADDR_WIDTH-1:0] query_addr,
  output logic                  query_busy,
  output logic                  bubble_req,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_value
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] value;
  } wr_t;

  wr_t           mem [QUEUE_DEPTH];
  wr_t           head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    starve_cnt;
  logic [7:0]    starve_nxt;
  logic          empty;
  logic          push;
  logic          pop;

  assign empty      = (count == '0);
  assign late_ready = (count != FULL);
  // x0 results are accepted but never stored
  assign push = late_valid && late_ready
             && (late_addr != '0);
  assign pop  = !commit_valid && !empty;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: late_addr,
                       value: late_value};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_value  <= '0;
    end else begin
      unique case (1'b1)
        commit_valid: begin
          write_enable <= (commit_addr != '0);
          if (commit_addr != '0) begin
            write_addr  <= commit_addr;
            write_value <= commit_value;
          end
        end
        pop: begin
          write_enable <= 1'b1;
          write_addr   <= head.addr;
          write_value  <= head.value;
        end
        default: write_enable <= 1'b0;
      endcase
    end
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (pop || empty) begin
      starve_nxt = '0;
    end else if (commit_valid && starve_cnt != 8'hff) begin
      starve_nxt = starve_cnt + 1'b1;
    end
  end

  // bubble tracks the updated count so it drops right after a pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      bubble_req <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      bubble_req <= (starve_nxt >= LIMIT);
    end
  end

  always_comb begin
    query_busy = 1'b0;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      if (CW'(k) < count
          && mem[rd_ptr + PW'(k)].addr == query_addr) begin
        query_busy = 1'b1;
      end
    end
    if (write_enable && write_addr == query_addr) begin
      query_busy = 1'b1;
    end
    if (query_addr == '0) begin
      query_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_int_reg_write_arbiter.sv
// Directed bench for int_reg_write_arbiter: commit, late path,
// full FIFO, starvation bubble and async reset scenarios.
module tb_int_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic        commit_valid;
  logic [4:0]  commit_addr;
  logic [31:0] commit_value;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_addr;
  logic [31:0] late_value;
  logic [4:0]  query_addr;
  logic        query_busy;
  logic        bubble_req;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_value;

  int n_cmp;
  int n_err;

  int_reg_write_arbiter #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .QUEUE_DEPTH(2),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .commit_valid(commit_valid),
    .commit_addr(commit_addr),
    .commit_value(commit_value),
    .late_valid(late_valid),
    .late_ready(late_ready),
    .late_addr(late_addr),
    .late_value(late_value),
    .query_addr(query_addr),
    .query_busy(query_busy),
    .bubble_req(bubble_req),
    .write_enable(write_enable),
    .write_addr(write_addr),
    .write_value(write_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag,
                        input logic we,
                        input logic [4:0] a,
                        input logic [31:0] v);
    check({tag, ".we"}, 32'(write_enable), 32'(we));
    check({tag, ".addr"}, 32'(write_addr), 32'(a));
    check({tag, ".value"}, write_value, v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst          = 1'b0;
    commit_valid = 1'b0;
    commit_addr  = '0;
    commit_value = '0;
    late_valid   = 1'b0;
    late_addr    = '0;
    late_value   = '0;
    query_addr   = '0;
    #1;
    chk_wr("rst", 1'b0, 5'd0, 32'h0);
    check("rst.ready", 32'(late_ready), 32'd1);
    check("rst.bubble", 32'(bubble_req), 32'd0);
    check("rst.busy", 32'(query_busy), 32'd0);
    step();
    step();
    rst = 1'b1;

    // commit only
    commit_valid = 1'b1;
    commit_addr  = 5'd3;
    commit_value = 32'hDEADBEEF;
    step();
    chk_wr("commit", 1'b1, 5'd3, 32'hDEADBEEF);
    commit_addr  = 5'd0;
    commit_value = 32'h1234;
    step();
    chk_wr("commit_x0", 1'b0, 5'd3, 32'hDEADBEEF);
    commit_valid = 1'b0;

    // late path with idle commit
    late_valid = 1'b1;
    late_addr  = 5'd7;
    late_value = 32'h55;
    query_addr = 5'd7;
    #1;
    check("late.busy_c1", 32'(query_busy), 32'd0);
    step();
    late_valid = 1'b0;
    #1;
    check("late.busy_c2", 32'(query_busy), 32'd1);
    check("late.we_c2", 32'(write_enable), 32'd0);
    check("late.ready_c2", 32'(late_ready), 32'd1);
    step();
    chk_wr("late.c3", 1'b1, 5'd7, 32'h55);
    check("late.busy_c3", 32'(query_busy), 32'd1);
    step();
    check("late.we_c4", 32'(write_enable), 32'd0);
    check("late.busy_c4", 32'(query_busy), 32'd0);

    // late write to x0 is dropped
    late_valid = 1'b1;
    late_addr  = 5'd0;
    late_value = 32'h99;
    step();
    late_valid = 1'b0;
    check("late_x0.we1", 32'(write_enable), 32'd0);
    step();
    check("late_x0.we2", 32'(write_enable), 32'd0);
    check("late_x0.ready", 32'(late_ready), 32'd1);

    // full FIFO, held request, push+pop at count 1
    commit_valid = 1'b1;
    commit_addr  = 5'd1;
    commit_value = 32'h100;
    late_valid   = 1'b1;
    late_addr    = 5'd10;
    late_value   = 32'hA0;
    step();
    chk_wr("full.commit", 1'b1, 5'd1, 32'h100);
    check("full.ready_b", 32'(late_ready), 32'd1);
    late_addr  = 5'd11;
    late_value = 32'hB0;
    step();
    check("full.ready_c", 32'(late_ready), 32'd0);
    late_addr  = 5'd12;
    late_value = 32'hC0;
    step();
    check("full.ready_d", 32'(late_ready), 32'd0);
    commit_valid = 1'b0;
    step();
    chk_wr("full.pop1", 1'b1, 5'd10, 32'hA0);
    check("full.ready_e", 32'(late_ready), 32'd1);
    step();
    late_valid = 1'b0;
    chk_wr("full.pop2", 1'b1, 5'd11, 32'hB0);
    check("full.ready_f", 32'(late_ready), 32'd1);
    step();
    chk_wr("full.pop3", 1'b1, 5'd12, 32'hC0);
    step();
    check("full.drained", 32'(write_enable), 32'd0);

    // starvation bubble
    commit_valid = 1'b1;
    commit_addr  = 5'd2;
    commit_value = 32'h22;
    late_valid   = 1'b1;
    late_addr    = 5'd5;
    late_value   = 32'h5;
    query_addr   = 5'd5;
    step();
    late_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("starve.low%0d", i),
            32'(bubble_req), 32'd0);
      step();
    end
    check("starve.high", 32'(bubble_req), 32'd1);
    check("starve.busy", 32'(query_busy), 32'd1);
    commit_valid = 1'b0;
    step();
    check("starve.clear", 32'(bubble_req), 32'd0);
    chk_wr("starve.pop", 1'b1, 5'd5, 32'h5);
    step();

    // async reset with two queued entries
    commit_valid = 1'b1;
    commit_addr  = 5'd4;
    commit_value = 32'h44;
    late_valid   = 1'b1;
    late_addr    = 5'd20;
    late_value   = 32'h1;
    query_addr   = 5'd20;
    step();
    late_addr  = 5'd21;
    late_value = 32'h2;
    step();
    late_valid = 1'b0;
    check("arst.ready_pre", 32'(late_ready), 32'd0);
    check("arst.we_pre", 32'(write_enable), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_wr("arst", 1'b0, 5'd0, 32'h0);
    check("arst.ready", 32'(late_ready), 32'd1);
    check("arst.bubble", 32'(bubble_req), 32'd0);
    check("arst.busy", 32'(query_busy), 32'd0);
    commit_valid = 1'b0;
    late_valid   = 1'b1;
    late_addr    = 5'd9;
    late_value   = 32'h9;
    step();
    late_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("arst.post%0d", i),
            32'(write_enable), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
